// File: rtl/ncl_pkg.sv
// NCL dual-rail code points and digit helpers
// shared by the pipeline stages and top level
package ncl_pkg;

  localparam logic [1:0] NCL_NULL    = 2'b00;
  localparam logic [1:0] NCL_DATA0   = 2'b01;
  localparam logic [1:0] NCL_DATA1   = 2'b10;
  localparam logic [1:0] NCL_ILLEGAL = 2'b11;

  function automatic logic digit_null(
    input logic [1:0] d
  );
    return d == NCL_NULL;
  endfunction

  function automatic logic digit_data(
    input logic [1:0] d
  );
    return (d == NCL_DATA0) || (d == NCL_DATA1);
  endfunction

  function automatic logic digit_illegal(
    input logic [1:0] d
  );
    return d == NCL_ILLEGAL;
  endfunction

endpackage

// File: rtl/ncl_pipeline_n_if.sv
// Dual-rail channel: rails flow forward,
// completion (ack) flows back to the producer
interface ncl_pipeline_n_if #(
  parameter int WIDTH = 4
);

  logic [2*WIDTH-1:0] rails;
  logic               ack;

  modport master (
    output rails,
    input  ack
  );

  modport slave (
    input  rails,
    output ack
  );

endinterface

// File: rtl/ncl_stage.sv
// One NCL register stage: a C-element per rail
// plus a completion register for the whole digit set
module ncl_stage
  import ncl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          init_n,
  ncl_pipeline_n_if.slave  up,
  ncl_pipeline_n_if.master dn
);

  localparam int RW = 2 * WIDTH;

  logic [RW-1:0] rail_q;
  logic [RW-1:0] rail_d;
  logic          comp_q;
  logic          comp_d;
  logic          en;
  logic          all_data;
  logic          all_null;

  // downstream completion gates which phase we accept
  assign en = ~dn.ack;

  // rail follows prev when prev agrees with en, else holds
  always_comb begin
    rail_d = (up.rails & {RW{en}})
           | (rail_q & (up.rails | {RW{en}}));
  end

  // completion: set on full DATA, clear on full NULL
  always_comb begin
    all_data = 1'b1;
    all_null = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (digit_null(rail_q[2*i +: 2])) begin
        all_data = 1'b0;
      end else begin
        all_null = 1'b0;
      end
    end
    comp_d = comp_q;
    if (all_data) begin
      comp_d = 1'b1;
    end else if (all_null) begin
      comp_d = 1'b0;
    end
  end

  // stage state register
  always_ff @(posedge clk) begin
    if (!init_n) begin
      rail_q <= '0;
      comp_q <= 1'b0;
    end else begin
      rail_q <= rail_d;
      comp_q <= comp_d;
    end
  end

  assign dn.rails = rail_q;
  assign up.ack   = comp_q;

endmodule

// File: rtl/ncl_pipeline_n.sv
// DEPTH-stage NCL pipeline with illegal-code
// detection and a delivered-wavefront counter
module ncl_pipeline_n
  import ncl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               init_n,
  input  logic [2*WIDTH-1:0] in_data,
  output logic               in_ack,
  output logic [2*WIDTH-1:0] out_data,
  input  logic               out_ack,
  output logic               illegal,
  output logic [CNT_W-1:0]   wave_cnt
);

  if (WIDTH < 1 || DEPTH < 2) begin : g_bad_cfg
    $error("ncl_pipeline_n: WIDTH>=1 and DEPTH>=2");
  end

  // link s feeds stage s; link DEPTH is the output
  ncl_pipeline_n_if #(.WIDTH(WIDTH)) ch [DEPTH+1] ();

  assign ch[0].rails   = in_data;
  assign ch[DEPTH].ack = out_ack;

  for (genvar s = 0; s < DEPTH; s++) begin : g_stage
    ncl_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk   (clk),
      .init_n(init_n),
      .up    (ch[s]),
      .dn    (ch[s+1])
    );
  end

  logic [2*WIDTH-1:0] out_rails;
  logic               comp_last;
  logic               out_full;
  logic               in_bad;
  logic               illegal_q;
  logic               illegal_d;
  logic [CNT_W-1:0]   wave_cnt_q;
  logic [CNT_W-1:0]   wave_cnt_d;

  assign out_rails = ch[DEPTH].rails;
  assign comp_last = ch[DEPTH-1].ack;

  // last stage completion rises next edge when full
  // and not yet complete; count that rise
  always_comb begin
    out_full = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (digit_null(out_rails[2*i +: 2])) begin
        out_full = 1'b0;
      end
    end
    wave_cnt_d = wave_cnt_q;
    if (out_full && !comp_last) begin
      wave_cnt_d = wave_cnt_q + CNT_W'(1);
    end
  end

  // sticky flag for any 11 digit on the input
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (digit_illegal(in_data[2*i +: 2])) begin
        in_bad = 1'b1;
      end
    end
    illegal_d = illegal_q | in_bad;
  end

  // top-level status registers
  always_ff @(posedge clk) begin
    if (!init_n) begin
      illegal_q  <= 1'b0;
      wave_cnt_q <= '0;
    end else begin
      illegal_q  <= illegal_d;
      wave_cnt_q <= wave_cnt_d;
    end
  end

  // outputs forced quiet while init_n is held low
  assign in_ack   = ch[0].ack & init_n;
  assign out_data = out_rails & {(2*WIDTH){init_n}};
  assign illegal  = illegal_q;
  assign wave_cnt = wave_cnt_q;

endmodule

// File: doc/ncl_pipeline_n.md
NCL_PIPELINE_N -- requirements
Module: ncl_pipeline_n

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of dual-rail digits per wavefront.
REQ-002 SHALL have parameter DEPTH, default 4: number of pipeline stages.
REQ-003 SHALL have parameter CNT_W, default 16: wavefront counter width.
REQ-004 SHALL have one clock and a synchronous, active-low reset: clk input 1, rising-edge clock; init_n input 1, synchronous active-low reset.
REQ-005 SHALL have port in_data, input, 2*WIDTH: source digits; digit i uses rails [2i+1:2i], bit 2i is DATA0 and bit 2i+1 is DATA1.
REQ-006 SHALL have port in_ack, output, 1: stage-0 completion; high means stage 0 holds a full DATA wavefront.
REQ-007 SHALL have port out_data, output, 2*WIDTH: rails of stage DEPTH-1.
REQ-008 SHALL have port out_ack, input, 1: consumer completion; high requests NULL, low requests DATA.
REQ-009 SHALL have port illegal, output, 1: sticky flag for an illegal code seen on in_data.
REQ-010 SHALL have port wave_cnt, output, CNT_W: count of DATA wavefronts delivered at the output.

Function
REQ-011 SHALL encode each digit as NULL=00, DATA0=01, DATA1=10 and ILLEGAL=11.
REQ-012 SHALL register every rail of stage s as a C-element each cycle: next = (prev & en_s) | (rail & (prev | en_s)); prev is in_data for s=0, otherwise stage s-1 rails.
REQ-013 SHALL register comp_s per stage: set when every digit of stage s is non-NULL, cleared when every digit is NULL, otherwise held.
REQ-014 SHALL drive en_s = ~comp_(s+1) combinationally, with en_(DEPTH-1) = ~out_ack.
REQ-015 SHALL drive in_ack = comp_0 and out_data = stage DEPTH-1 rails.
REQ-016 SHALL give these latencies for an empty pipeline with out_ack=0 and DATA on in_data before edge 1:
- stage s rails valid after edge s+1;
- out_data valid after edge DEPTH;
- in_ack high after edge 2.
REQ-017 SHALL, for a partial wavefront, let individual digits advance per REQ-012 while comp holds its prior value; partial DATA is never acknowledged.
REQ-018 SHALL hold a stage's DATA while its enable is low, and hold its NULL while its enable is high; no overwrite of an unacknowledged wavefront.
REQ-019 SHALL set illegal on the edge after any in_data digit reads 11, and hold it until reset.
REQ-020 SHALL propagate illegal rails per REQ-012 with no special handling.
REQ-021 SHALL increment wave_cnt on the edge at which comp_(DEPTH-1) goes 0 to 1; it wraps modulo 2^CNT_W.
REQ-022 SHALL give simultaneous events no priority: each stage uses only previous-cycle values; enable and completion changes in the same cycle are resolved per REQ-012/REQ-013.
REQ-023 SHALL support WIDTH>=1 and DEPTH>=2; other values are a configuration error (elaboration assertion).

Reset
REQ-024 SHALL, on any clk edge with init_n=0, clear all rails to NULL and all comp_s to 0, and clear illegal and wave_cnt to 0.
REQ-025 SHALL, during reset, drive in_ack=0 and out_data=0.
REQ-026 SHALL treat reset mid-operation as discarding all in-flight wavefronts; the first edge after release evaluates normally.

Structure
REQ-027 SHALL place rail-code constants (NULL, DATA0, DATA1, ILLEGAL) in shared package ncl_pkg.
REQ-028 SHALL implement one stage as sub-module ncl_stage (WIDTH digits, rail C-elements, comp register), instantiated DEPTH times by generate.
REQ-029 SHALL keep the illegal detector and wave_cnt in the top level.

Verification (WIDTH=2, DEPTH=4)
REQ-030 SHALL cover empty-pipeline latency: in_data=0101, out_ack=0 -> out_data=0101 after edge 4, in_ack=1 after edge 2, wave_cnt=1 after edge 5.
REQ-031 SHALL cover backpressure: out_ack held 1 with a second DATA 1010 following NULL -> stage 3 keeps NULL; the wavefront stalls in stage 2; no loss on out_ack release.
REQ-032 SHALL cover a closed loop: the source drives DATA 0110 when in_ack=0 and NULL when in_ack=1, and the consumer echoes comp of out_data -> wave_cnt strictly increasing, illegal=0, over 200 cycles.
REQ-033 SHALL cover partial wavefronts: in_data=0100 for 10 cycles -> in_ack stays 0; then 0110 -> in_ack=1 two edges later.
REQ-034 SHALL cover illegal input: in_data=1101 for one cycle -> illegal=1 next edge and persistent until init_n=0.
REQ-035 SHALL cover reset mid-flight: init_n=0 for one edge with wavefronts in stages 1-3 -> all outputs 0, wave_cnt=0 after that edge.
